// File: rtl/comm_activity_detector.sv
// Bus activity detector: synchronizes raw SPI/UART pins, detects edges and holds
// comm_active until the bus has been quiet for IDLE_TIMEOUT_US. Define
// COMM_ACTIVITY_LINE_MASK_EN to add a per-line line_mask input.
module comm_activity_detector #(
  parameter int NUM_LINES       = 4,
  parameter int SYS_FREQ_HZ     = 12_000_000,
  parameter int IDLE_TIMEOUT_US = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic [NUM_LINES-1:0]   bus_lines,
  input  logic                   enable,
`ifdef COMM_ACTIVITY_LINE_MASK_EN
  input  logic [NUM_LINES-1:0]   line_mask,
`endif
  output logic                   comm_active,
  output logic                   burst_start,
  output logic [COUNT_WIDTH-1:0] burst_count
);

  localparam int TIMEOUT_CYCLES = (SYS_FREQ_HZ / 1_000_000) * IDLE_TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_PRIME  = 2'd0;
  localparam logic [1:0] S_IDLE   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [SYNC_STAGES-1:0][NUM_LINES-1:0] sync_q;
  logic [SYNC_STAGES:0]                  vld_pipe_q;
  logic [NUM_LINES-1:0]                  prev_q, edge_q, mask;
  logic [1:0]                            state_q, state_d;
  logic [TW-1:0]                         cnt_q, cnt_d;
  logic                                  active_q, active_d, start_q, start_d;
  logic [COUNT_WIDTH-1:0]                bcnt_q, bcnt_d;
  logic                                  any_edge;

`ifdef COMM_ACTIVITY_LINE_MASK_EN
  assign mask = line_mask;
`else
  assign mask = '1;
`endif

  // vld_pipe_q marks which synchronizer stages (and finally prev_q) hold real
  // post-reset samples, so reset zeros never read as an edge on lines idling high.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      prev_q     <= '0;
      edge_q     <= '0;
    end else begin
      sync_q[0] <= bus_lines;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      vld_pipe_q <= {vld_pipe_q[SYNC_STAGES-1:0], 1'b1};
      prev_q     <= sync_q[SYNC_STAGES-1];
      edge_q     <= (sync_q[SYNC_STAGES-1] ^ prev_q) & {NUM_LINES{vld_pipe_q[SYNC_STAGES]}};
    end
  end

  assign any_edge = (|(edge_q & mask)) && enable && (state_q != S_PRIME);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    start_d  = 1'b0;
    bcnt_d   = bcnt_q;
    case (state_q)
      S_PRIME: state_d = S_IDLE;
      S_IDLE: begin
        active_d = 1'b0;
        if (any_edge) begin
          state_d  = S_ACTIVE;
          active_d = 1'b1;
          start_d  = 1'b1;
          cnt_d    = RELOAD;
          if (!(&bcnt_q)) bcnt_d = bcnt_q + COUNT_WIDTH'(1);
        end
      end
      S_ACTIVE: begin
        if (!enable) begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end else if (any_edge) begin
          cnt_d = RELOAD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - TW'(1);
        end else begin
          state_d  = S_IDLE;
          active_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q  <= S_PRIME;
      cnt_q    <= '0;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      start_q  <= start_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign comm_active = active_q;
  assign burst_start = start_q;
  assign burst_count = bcnt_q;

endmodule

// File: tb/tb_comm_activity_detector.sv
// Scoreboard bench for comm_activity_detector: stimulus pushes expected burst starts
// and comm_active falls; a negedge monitor pops and compares them.
module tb_comm_activity_detector;
  logic        clk = 1'b0;
  logic        rst, enable;
  logic [3:0]  bus_lines;
  logic        comm_active, burst_start, comm_active2, burst_start2;
  logic [15:0] burst_count;
  logic [1:0]  burst_count2;
`ifdef COMM_ACTIVITY_LINE_MASK_EN
  logic [3:0]  line_mask;
`endif

  always #5 clk = ~clk;

  comm_activity_detector dut (
    .sys_clk(clk), .rst(rst), .bus_lines(bus_lines), .enable(enable),
`ifdef COMM_ACTIVITY_LINE_MASK_EN
    .line_mask(line_mask),
`endif
    .comm_active(comm_active), .burst_start(burst_start), .burst_count(burst_count));

  comm_activity_detector #(.COUNT_WIDTH(2)) dut2 (
    .sys_clk(clk), .rst(rst), .bus_lines(bus_lines), .enable(enable),
`ifdef COMM_ACTIVITY_LINE_MASK_EN
    .line_mask(line_mask),
`endif
    .comm_active(comm_active2), .burst_start(burst_start2), .burst_count(burst_count2));

  typedef struct { int cyc; int cnt; } start_t;
  start_t start_q[$];
  int     fall_q[$];
  int     cyc = 0;
  int     n_chk = 0, n_pass = 0;
  int     exp_cnt = 0;
  bit     prev_act = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Toggle a line just after a negedge; m is the cycle count at that moment.
  task automatic tog(input int ln, output int m);
    @(negedge clk);
    bus_lines[ln] = ~bus_lines[ln];
    m = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pin sampled at edge m+1 -> burst_start registered at edge m+4.
  task automatic exp_start(input int m);
    start_t e;
    exp_cnt++;
    e.cyc = m + 4;
    e.cnt = exp_cnt;
    start_q.push_back(e);
  endtask

  always @(negedge clk) begin
    start_t e;
    int     f;
    if (burst_start) begin
      chk("start_expected", start_q.size() != 0, 1);
      if (start_q.size() != 0) begin
        e = start_q.pop_front();
        chk("start_cycle", cyc, e.cyc);
        chk("burst_count", burst_count, e.cnt);
        chk("dut2_start", burst_start2, 1);
        chk("dut2_sat_count", burst_count2, (e.cnt > 3) ? 3 : e.cnt);
      end
    end
    if (!prev_act && comm_active) chk("rise_has_start", burst_start, 1);
    if (prev_act && !comm_active) begin
      chk("fall_expected", fall_q.size() != 0, 1);
      if (fall_q.size() != 0) begin
        f = fall_q.pop_front();
        chk("fall_cycle", cyc, f);
      end
    end
    prev_act = comm_active;
  end

  initial begin
    int m, m2;
    rst = 1'b1; enable = 1'b1; bus_lines = 4'b1111;
`ifdef COMM_ACTIVITY_LINE_MASK_EN
    line_mask = 4'b1111;
`endif
    idle(4);
    chk("rst_comm_active", comm_active, 0);
    chk("rst_burst_start", burst_start, 0);
    chk("rst_burst_count", burst_count, 0);
    chk("rst_dut2_count", burst_count2, 0);
    rst = 1'b0;

    // Lines idle high after reset: no false burst.
    idle(500);
    chk("quiet_count", burst_count, 0);
    chk("quiet_active", comm_active, 0);

    // Single toggle.
    tog(0, m); exp_start(m); fall_q.push_back(m + 124);
    idle(130);
    chk("single_count", burst_count, 1);

    // Ten toggles 50 cycles apart merge into one burst.
    for (int i = 0; i < 10; i++) begin
      tog(2, m);
      if (i == 0) exp_start(m);
      if (i < 9) idle(49);
    end
    fall_q.push_back(m + 124);
    idle(130);
    chk("merged_count", burst_count, 2);

    // 200-cycle gap: separate bursts.
    for (int i = 0; i < 2; i++) begin
      tog(2, m); exp_start(m); fall_q.push_back(m + 124);
      idle(199);
    end

    // Edge in the counter==0 cycle extends the burst.
    tog(1, m); exp_start(m);
    idle(119);
    tog(1, m2); fall_q.push_back(m2 + 124);
    idle(130);
    chk("edge_wins_count", burst_count, 5);

    // One cycle later: burst ends, new one starts right after.
    tog(3, m); exp_start(m); fall_q.push_back(m + 124);
    idle(120);
    tog(3, m2); exp_start(m2); fall_q.push_back(m2 + 124);
    idle(130);

    // Enable dropped mid-burst, toggles while disabled, re-enable.
    tog(0, m); exp_start(m);
    idle(30);
    enable = 1'b0;
    fall_q.push_back(m + 31);
    for (int i = 0; i < 4; i++) begin
      tog(i, m2);
      idle(5);
    end
    idle(10);
    chk("disabled_count", burst_count, exp_cnt);
    chk("disabled_active", comm_active, 0);
    enable = 1'b1;
    idle(5);
    tog(0, m); exp_start(m); fall_q.push_back(m + 124);
    idle(130);
    chk("reenable_count", burst_count, 9);

    // Reset mid-burst.
    tog(1, m); exp_start(m);
    idle(20);
    rst = 1'b1;
    fall_q.push_back(m + 21);
    exp_cnt = 0;
    idle(1);
    chk("midrst_count", burst_count, 0);
    chk("midrst_start", burst_start, 0);
    rst = 1'b0;
    idle(20);
    tog(2, m); exp_start(m); fall_q.push_back(m + 124);
    idle(130);

`ifdef COMM_ACTIVITY_LINE_MASK_EN
    line_mask = 4'b1110;
    idle(3);
    tog(0, m);
    idle(130);
    chk("masked_count", burst_count, exp_cnt);
    tog(1, m); exp_start(m); fall_q.push_back(m + 124);
    idle(130);
    line_mask = 4'b1111;
    idle(5);
`endif

    chk("start_q_drained", start_q.size(), 0);
    chk("fall_q_drained", fall_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/comm_activity_detector.md
Name: comm_activity_detector

Overview:
Monitors the raw MITM bus lines (SPI/UART pins) for signal transitions and produces the `comm_active` level that feeds the I/O handler's activity LED.
- Synchronizes the asynchronous bus lines and detects edges on them.
- Holds `comm_active` high until the bus has been quiet for a programmable timeout.
- Counts communication bursts for debug readout.
- Sits directly upstream of the I/O handler, on the same `sys_clk` domain, reset by its `debounced_rst` output.

Parameters:
- NUM_LINES, 4, number of monitored bus lines.
- SYS_FREQ_HZ, 12_000_000, system clock frequency in Hz.
- IDLE_TIMEOUT_US, 10, quiet time (µs) after the last edge before `comm_active` drops.
- SYNC_STAGES, 2, flip-flop synchronizer depth per line; legal range 2..4.
- COUNT_WIDTH, 16, width of the burst counter.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset (driven by `debounced_rst`).
- bus_lines  input  NUM_LINES  raw asynchronous bus pins.
- enable  input  1  monitoring enable; synchronous to `sys_clk`.
- comm_active  output  1  high while a burst is in progress.
- burst_start  output  1  one-cycle pulse on each IDLE->ACTIVE transition.
- burst_count  output  COUNT_WIDTH  number of bursts since reset; saturating.

Behaviour:
- Interface: one clock (`sys_clk`); reset is synchronous and active-high (`rst`).
- Reset values: `comm_active`=0, `burst_start`=0, `burst_count`=0, all synchronizer flops=0, state=PRIME.
- TIMEOUT_CYCLES = (SYS_FREQ_HZ/1_000_000)*IDLE_TIMEOUT_US. Default is 120. The down-counter is sized with $clog2(TIMEOUT_CYCLES+1).
- Each line passes through SYNC_STAGES flops. `prev` holds the last synchronized value. edge[i] = sync[i] XOR prev[i]. `prev` updates every cycle, including while `enable`=0.
- any_edge = OR of edge[]; it is forced to 0 in PRIME and whenever `enable`=0.
- PRIME: lasts exactly 1 cycle after reset is released. Loads `prev`, detects no edges, then goes to IDLE. This prevents a false burst from lines that idle high after reset.
- IDLE: `comm_active`=0. On any_edge: go to ACTIVE, load counter=TIMEOUT_CYCLES-1, pulse `burst_start` for 1 cycle, increment `burst_count`.
- ACTIVE: `comm_active`=1.
  - any_edge: reload counter=TIMEOUT_CYCLES-1.
  - Otherwise, counter>0: decrement.
  - Otherwise, counter==0: go to IDLE.
- Timing: `comm_active` falls exactly TIMEOUT_CYCLES cycles after the cycle holding the last detected edge.
- Latency: a pin change sampled at clock edge k gives `comm_active`=1 and `burst_start`=1 registered at edge k+SYNC_STAGES+1.
- Outputs are registered; no combinational path from `bus_lines` to any output.
- `burst_count` saturates at 2^COUNT_WIDTH-1. `burst_start` still pulses at saturation.
- `enable` falling while ACTIVE: next cycle state=IDLE and `comm_active`=0. `burst_count` is retained.
- `enable` rising: an edge needs a real transition after enable is high. A level that differs from `prev` cannot exist at that point, because `prev` keeps tracking while disabled.
- Edge in the same cycle the counter reaches 0: the edge wins. Counter reloads and the state stays ACTIVE; no new burst is counted.
- Simultaneous edges on several lines: treated as a single event.
- `rst` asserted mid-burst: all outputs return to reset values on the next edge, then PRIME.

Optional Feature:
- Macro: COMM_ACTIVITY_LINE_MASK_EN.
- Defined: adds input port `line_mask` [NUM_LINES-1:0], synchronous. A line with mask bit 0 is excluded from any_edge; its synchronizer and `prev` keep running. Changing the mask never generates an edge by itself.
- Undefined: the port is absent and all lines are monitored.

Test Plan:
- Reset release with `bus_lines`=4'b1111, `enable`=1, no toggling for 500 cycles -> `comm_active`=0, `burst_start` never pulses, `burst_count`=0.
- Single toggle on line 0 at edge k -> `comm_active`=1 and a 1-cycle `burst_start` at k+3; `comm_active` falls exactly 120 cycles after the detected edge; `burst_count`=1.
- Toggles on line 2 every 50 cycles ×10, then quiet -> one continuous `comm_active` pulse, `burst_count`=1; falls 120 cycles after the last edge. Repeat with a 200-cycle gap -> `burst_count`=2.
- Edge arriving in the cycle where the counter==0 -> `comm_active` stays high with no glitch, `burst_count` unchanged.
- `enable` dropped mid-burst -> `comm_active`=0 the next cycle; toggles while disabled -> no bursts; re-enable plus one toggle -> `burst_count` increments by 1.
- COUNT_WIDTH=2 with 5 separate bursts -> `burst_count` saturates at 3. With COMM_ACTIVITY_LINE_MASK_EN and `line_mask`=4'b1110, toggling line 0 -> no activity; toggling line 1 -> a burst.
